draw_lever_anim: RTL and testbench



---
 rtl/draw_lever_anim_if.sv | 14 +
 rtl/draw_lever_anim.sv | 157 +++++++++++++++
 tb/tb_draw_lever_anim.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/draw_lever_anim_if.sv
// VGA pipeline bundle: timing counters, sync/blank strobes and 12-bit colour.
// Each overlay stage takes one bundle in and drives the next one out.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_lever_anim.sv
// Multi-position lever sprite: frame, slot, sliding handle and optional highlight ring.
// The handle glides one pixel per STEP_FRAMES frames between detents on move requests.
module draw_lever_anim #(
  parameter int          LEVER_X     = 100,
  parameter int          LEVER_Y     = 100,
  parameter int          WIDTH       = 100,
  parameter int          HEIGHT      = 50,
  parameter int          SLOT_INSET  = 5,
  parameter int          KNOB_W      = 10,
  parameter int          N_POS       = 3,
  parameter int          INIT_POS    = 1,
  parameter int          STEP_FRAMES = 1,
  parameter int          HL_RANGE    = 3,
  parameter logic [11:0] HL_COLOR    = 12'h060,
  parameter logic [11:0] KNOB_COLOR  = 12'hC20
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_if.in                        vga_in,
  vga_if.out                       vga_out,
  input  logic                     highlight_en,
  input  logic                     move_req,
  input  logic                     move_up,
  output logic                     busy,
  output logic                     move_done,
  output logic [$clog2(N_POS)-1:0] lever_pos
);

  localparam int POS_W   = $clog2(N_POS);
  localparam int OFF_W   = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(STEP_FRAMES + 1);
  localparam int STEP_PX = (WIDTH - 2*SLOT_INSET - KNOB_W) / (N_POS - 1);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] ONE_POS  = POS_W'(1);
  localparam logic [OFF_W-1:0] ONE_OFF  = OFF_W'(1);
  localparam logic [OFF_W-1:0] INIT_OFF = OFF_W'(INIT_POS * STEP_PX);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DONE} state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] target, target_nxt, pos_nxt;
  logic [OFF_W-1:0] knob_off, off_nxt, target_off;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             frame_tick;
  logic             dir_legal;

  assign frame_tick = (vga_in.hcount == '0) && (vga_in.vcount == '0);
  assign target_off = OFF_W'(int'(target) * STEP_PX);
  assign dir_legal  = move_up ? (lever_pos != LAST_POS) : (lever_pos != '0);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    pos_nxt    = lever_pos;
    off_nxt    = knob_off;
    cnt_nxt    = frame_cnt;
    busy       = 1'b0;
    move_done  = 1'b0;
    case (state)
      IDLE: begin
        if (move_req && dir_legal) begin
          target_nxt = move_up ? lever_pos + ONE_POS : lever_pos - ONE_POS;
          cnt_nxt    = '0;
          state_nxt  = MOVING;
        end
      end
      MOVING: begin
        busy = 1'b1;
        if (knob_off == target_off) begin
          pos_nxt   = target;
          state_nxt = DONE;
        end else if (frame_tick) begin
          if (frame_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            off_nxt = (knob_off < target_off) ? knob_off + ONE_OFF : knob_off - ONE_OFF;
          end else begin
            cnt_nxt = frame_cnt + ONE_CNT;
          end
        end
      end
      DONE: begin
        move_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= POS_W'(INIT_POS);
      lever_pos <= POS_W'(INIT_POS);
      knob_off  <= INIT_OFF;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      lever_pos <= pos_nxt;
      knob_off  <= off_nxt;
      frame_cnt <= cnt_nxt;
    end
  end

  // Pixel classification runs on the incoming coordinates; result lands with the registered timing.
  int   hx, vy, kx0;
  logic in_slot_y, in_knob, in_slot, in_frame, in_ring_box, in_ring;
  logic [11:0] rgb_nxt;

  assign hx  = int'(vga_in.hcount);
  assign vy  = int'(vga_in.vcount);
  assign kx0 = LEVER_X + SLOT_INSET + int'(knob_off);

  assign in_slot_y   = (vy >= LEVER_Y + SLOT_INSET) && (vy <= LEVER_Y + HEIGHT - 1 - SLOT_INSET);
  assign in_knob     = in_slot_y && (hx >= kx0) && (hx <= kx0 + KNOB_W - 1);
  assign in_slot     = in_slot_y && (hx >= LEVER_X + SLOT_INSET)
                                 && (hx <= LEVER_X + WIDTH - 1 - SLOT_INSET);
  assign in_frame    = (hx >= LEVER_X) && (hx <= LEVER_X + WIDTH - 1)
                    && (vy >= LEVER_Y) && (vy <= LEVER_Y + HEIGHT - 1);
  assign in_ring_box = (hx >= LEVER_X - HL_RANGE) && (hx <= LEVER_X + WIDTH - 1 + HL_RANGE)
                    && (vy >= LEVER_Y - HL_RANGE) && (vy <= LEVER_Y + HEIGHT - 1 + HL_RANGE);
  assign in_ring     = highlight_en && in_ring_box && !in_frame;

  always_comb begin
    rgb_nxt = vga_in.rgb;
    if (in_knob)       rgb_nxt = KNOB_COLOR;
    else if (in_slot)  rgb_nxt = 12'h333;
    else if (in_frame) rgb_nxt = 12'h777;
    else if (in_ring)  rgb_nxt = HL_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vga_in.vcount;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.hcount <= vga_in.hcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.rgb    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_lever_anim.sv
// Directed bench for draw_lever_anim: reset state, handle rendering, detent moves,
// illegal/ignored requests, highlight ring, mid-move reset and video pass-through.
module tb_draw_lever_anim;

  logic       clk = 1'b0;
  logic       rst, highlight_en, move_req, move_up;
  logic       busy, move_done;
  logic [1:0] lever_pos;

  vga_if vin();
  vga_if vout();

  always #5 clk = ~clk;

  draw_lever_anim dut (
    .clk          (clk),
    .rst          (rst),
    .vga_in       (vin),
    .vga_out      (vout),
    .highlight_en (highlight_en),
    .move_req     (move_req),
    .move_up      (move_up),
    .busy         (busy),
    .move_done    (move_done),
    .lever_pos    (lever_pos)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  always @(negedge clk) if (move_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int h, input int v);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] exp, input string tag);
    set_pix(h, v);
    step();
    check(tag, 32'(vout.rgb), 32'(exp));
    set_pix(1000, 1000);
  endtask

  task automatic tick();
    set_pix(0, 0);
    step();
    set_pix(1000, 1000);
  endtask

  // Full detent move of 40 px; a reverse request mid-motion must be ignored.
  task automatic move(input logic up, input logic [1:0] exp_pos, input string tag);
    move_req = 1'b1;
    move_up  = up;
    step();
    move_req = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 10) begin
        move_req = 1'b1;
        move_up  = ~up;
        step();
        move_req = 1'b0;
      end
    end
    check({tag, "_busy_last_tick"}, 32'(busy), 32'd1);
    check({tag, "_no_early_done"}, 32'(move_done), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(move_done), 32'd1);
    check({tag, "_busy_cleared"}, 32'(busy), 32'd0);
    check({tag, "_pos"}, 32'(lever_pos), 32'(exp_pos));
  endtask

  initial begin
    rst          = 1'b1;
    highlight_en = 1'b0;
    move_req     = 1'b0;
    move_up      = 1'b0;
    vin.hsync    = 1'b1;
    vin.vsync    = 1'b1;
    vin.hblnk    = 1'b1;
    vin.vblnk    = 1'b1;
    vin.rgb      = 12'hABC;
    set_pix(1000, 1000);
    step();
    step();

    check("rst_rgb",    32'(vout.rgb),    32'h0);
    check("rst_hsync",  32'(vout.hsync),  32'h0);
    check("rst_vsync",  32'(vout.vsync),  32'h0);
    check("rst_hblnk",  32'(vout.hblnk),  32'h0);
    check("rst_vblnk",  32'(vout.vblnk),  32'h0);
    check("rst_hcount", 32'(vout.hcount), 32'h0);
    check("rst_busy",   32'(busy),        32'h0);
    check("rst_done",   32'(move_done),   32'h0);
    check("rst_pos",    32'(lever_pos),   32'd1);

    rst = 1'b0;
    tick();
    probe(145, 105, 12'hC20, "knob_left_edge");
    probe(144, 105, 12'h333, "slot_left_of_knob");
    probe(154, 105, 12'hC20, "knob_right_edge");
    probe(155, 105, 12'h333, "slot_right_of_knob");
    probe(150, 144, 12'hC20, "knob_last_row");
    probe(150, 104, 12'h777, "frame_above_slot");
    probe(100, 100, 12'h777, "frame_top_left");
    probe(199, 149, 12'h777, "frame_bottom_right");
    probe(99, 100, 12'hABC, "outside_no_ring");
    check("idle_busy", 32'(busy), 32'd0);

    move(1'b1, 2'd2, "up_1_to_2");
    step();
    check("done_one_cycle", 32'(move_done), 32'd0);
    check("done_count_1", 32'(done_cnt), 32'd1);
    probe(185, 105, 12'hC20, "knob_at_80");
    probe(184, 105, 12'h333, "slot_left_of_80");
    probe(194, 105, 12'hC20, "knob_end_at_80");

    move_req = 1'b1;
    move_up  = 1'b1;
    step();
    move_req = 1'b0;
    check("illegal_up_busy", 32'(busy), 32'd0);
    step();
    check("illegal_up_done", 32'(move_done), 32'd0);
    check("illegal_up_pos", 32'(lever_pos), 32'd2);

    move(1'b0, 2'd1, "down_2_to_1");
    step();
    move(1'b0, 2'd0, "down_1_to_0");
    move_req = 1'b1;
    move_up  = 1'b1;
    step();
    move_req = 1'b0;
    check("done_cycle_req_ignored", 32'(busy), 32'd0);
    step();
    check("done_cycle_req_still_idle", 32'(busy), 32'd0);
    check("done_cycle_req_pos", 32'(lever_pos), 32'd0);
    check("done_count_3", 32'(done_cnt), 32'd3);

    move_req = 1'b1;
    move_up  = 1'b0;
    step();
    move_req = 1'b0;
    check("illegal_down_busy", 32'(busy), 32'd0);
    step();
    check("illegal_down_done", 32'(move_done), 32'd0);
    check("illegal_down_pos", 32'(lever_pos), 32'd0);
    probe(105, 105, 12'hC20, "knob_at_0");
    probe(115, 105, 12'h333, "slot_right_of_0");

    highlight_en = 1'b1;
    probe(99, 100, 12'h060, "ring_left_inner");
    probe(97, 100, 12'h060, "ring_left_outer");
    probe(96, 100, 12'hABC, "beyond_ring");
    probe(202, 152, 12'h060, "ring_bottom_right");
    probe(203, 152, 12'hABC, "beyond_ring_br");
    probe(150, 120, 12'h333, "slot_over_ring");
    highlight_en = 1'b0;
    probe(99, 100, 12'hABC, "ring_off");

    move(1'b1, 2'd1, "up_0_to_1");
    step();
    check("done_count_4", 32'(done_cnt), 32'd4);
    move_req = 1'b1;
    move_up  = 1'b1;
    step();
    move_req = 1'b0;
    check("partial_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    probe(165, 105, 12'hC20, "knob_at_60");
    probe(164, 105, 12'h333, "slot_left_of_60");

    rst = 1'b1;
    step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pos", 32'(lever_pos), 32'd1);
    check("midrst_rgb", 32'(vout.rgb), 32'h0);
    check("midrst_hsync", 32'(vout.hsync), 32'h0);
    rst = 1'b0;
    step();
    step();
    check("midrst_no_done", 32'(move_done), 32'd0);
    check("midrst_done_count", 32'(done_cnt), 32'd4);
    probe(145, 105, 12'hC20, "midrst_knob_snap");
    probe(165, 105, 12'h333, "midrst_old_knob_gone");

    vin.hsync = 1'b1;
    vin.vsync = 1'b0;
    vin.hblnk = 1'b1;
    vin.vblnk = 1'b0;
    vin.rgb   = 12'hABC;
    set_pix(1000, 1000);
    step();
    check("pass_rgb", 32'(vout.rgb), 32'hABC);
    check("pass_hsync", 32'(vout.hsync), 32'd1);
    check("pass_vsync", 32'(vout.vsync), 32'd0);
    check("pass_hblnk", 32'(vout.hblnk), 32'd1);
    check("pass_vblnk", 32'(vout.vblnk), 32'd0);
    check("pass_hcount", 32'(vout.hcount), 32'd1000);
    vin.hsync = 1'b0;
    vin.vsync = 1'b1;
    vin.hblnk = 1'b0;
    vin.vblnk = 1'b1;
    vin.rgb   = 12'h123;
    set_pix(1001, 999);
    #1;
    check("hold_hsync", 32'(vout.hsync), 32'd1);
    check("hold_rgb", 32'(vout.rgb), 32'hABC);
    step();
    check("delay_hsync", 32'(vout.hsync), 32'd0);
    check("delay_vsync", 32'(vout.vsync), 32'd1);
    check("delay_hblnk", 32'(vout.hblnk), 32'd0);
    check("delay_vblnk", 32'(vout.vblnk), 32'd1);
    check("delay_rgb", 32'(vout.rgb), 32'h123);
    check("delay_hcount", 32'(vout.hcount), 32'd1001);
    check("delay_vcount", 32'(vout.vcount), 32'd999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
